// File: rtl/wb_search_master.sv
// Wishbone master that resets a search unit, polls it until it reports done, reads back the
// energy and 72-bit sequence result, and hands them out over a valid/ready port.
// Optional poll timeout: define WB_SEARCH_TIMEOUT_EN.
module wb_search_master #(
    parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
    parameter int          E_WIDTH        = 16,
    parameter int          POLL_GAP       = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [3:0]         wbm_sel_o,
    output logic [31:0]        wbm_adr_o,
    output logic [31:0]        wbm_dat_o,
    input  logic [31:0]        wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [71:0]        o_seq,
    output logic [E_WIDTH-1:0] o_e,
    output logic               o_timeout
);

    if (POLL_GAP < 1 || POLL_GAP > 255) begin : g_bad_poll_gap
        $error("wb_search_master: POLL_GAP must be in 1..255");
    end
    if (TIMEOUT_CYCLES == 32'd0) begin : g_bad_timeout
        $error("wb_search_master: TIMEOUT_CYCLES must be non-zero");
    end

    localparam logic [31:0] OFF_STAT = 32'h00;
    localparam logic [31:0] OFF_CTRL = 32'h04;
    localparam logic [31:0] OFF_E    = 32'h08;
    localparam logic [31:0] OFF_S0   = 32'h10;
    localparam logic [31:0] OFF_S1   = 32'h14;
    localparam logic [31:0] OFF_S2   = 32'h18;
    localparam logic [7:0]  GAP_LOAD = 8'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        IDLE, RST_SET, RST_CLR, POLL, GAP, RD_E, RD_S0, RD_S1, RD_S2, OUT
    } state_t;

    state_t             state_q, state_d;
    logic               cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [31:0]        adr_q, adr_d, dat_o_q, dat_o_d;
    logic [71:0]        seq_q, seq_d;
    logic [E_WIDTH-1:0] e_q, e_d;
    logic               valid_q, valid_d, busy_q, busy_d;
    logic [7:0]         gap_q, gap_d;
    logic               tmo_q, tmo_d;
    logic [31:0]        tx_adr, tx_dat;
    logic               tx_we;
`ifdef WB_SEARCH_TIMEOUT_EN
    logic [31:0]        tmo_cnt_q, tmo_cnt_d;
    logic               tmo_hit;
`endif

    // Address/direction/data of the transaction owned by each bus state.
    always_comb begin
        tx_adr = BASE_ADR | OFF_STAT;
        tx_we  = 1'b0;
        tx_dat = 32'h0;
        case (state_q)
            RST_SET: begin tx_adr = BASE_ADR | OFF_CTRL; tx_we = 1'b1; tx_dat = 32'h1; end
            RST_CLR: begin tx_adr = BASE_ADR | OFF_CTRL; tx_we = 1'b1; end
            RD_E:    tx_adr = BASE_ADR | OFF_E;
            RD_S0:   tx_adr = BASE_ADR | OFF_S0;
            RD_S1:   tx_adr = BASE_ADR | OFF_S1;
            RD_S2:   tx_adr = BASE_ADR | OFF_S2;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_o_d = dat_o_q;
        seq_d   = seq_q;
        e_d     = e_q;
        valid_d = valid_q;
        gap_d   = gap_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: if (i_start) state_d = RST_SET;
            GAP: begin
                if (gap_q == 8'd0) state_d = POLL;
                else               gap_d   = gap_q - 8'd1;
            end
            OUT: begin
                if (valid_q && i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                // A bus state launches on its first cycle with stb low, which also
                // provides the single idle cycle after the previous ack.
                if (!stb_q) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = tx_we;
                    adr_d   = tx_adr;
                    dat_o_d = tx_dat;
                end else if (wbm_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    case (state_q)
                        RST_SET: state_d = RST_CLR;
                        RST_CLR: state_d = POLL;
                        POLL: begin
                            if (wbm_dat_i[0]) state_d = RD_E;
                            else begin
                                state_d = GAP;
                                gap_d   = GAP_LOAD;
                            end
                        end
                        RD_E: begin
                            e_d     = wbm_dat_i[E_WIDTH-1:0];
                            state_d = RD_S0;
                        end
                        RD_S0: begin
                            seq_d[31:0] = wbm_dat_i;
                            state_d     = RD_S1;
                        end
                        RD_S1: begin
                            seq_d[63:32] = wbm_dat_i;
                            state_d      = RD_S2;
                        end
                        RD_S2: begin
                            seq_d[71:64] = wbm_dat_i[7:0];
                            valid_d      = 1'b1;
                            state_d      = OUT;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase

`ifdef WB_SEARCH_TIMEOUT_EN
        // An open poll is allowed to complete; a done seen on that last poll still wins.
        if (tmo_hit && (state_q == POLL || state_q == GAP)) begin
            if (!stb_q) begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                we_d    = 1'b0;
                tmo_d   = 1'b1;
            end else if (wbm_ack_i && !wbm_dat_i[0]) begin
                state_d = IDLE;
                tmo_d   = 1'b1;
            end
        end
`endif
        busy_d = (state_d != IDLE);
    end

`ifdef WB_SEARCH_TIMEOUT_EN
    assign tmo_hit = (tmo_cnt_q >= TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        tmo_cnt_d = 32'd0;
        if (state_q == POLL || state_q == GAP)
            tmo_cnt_d = tmo_hit ? tmo_cnt_q : tmo_cnt_q + 32'd1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) tmo_cnt_q <= 32'd0;
        else            tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'h0;
            dat_o_q <= 32'h0;
            seq_q   <= 72'h0;
            e_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            gap_q   <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_o_q <= dat_o_d;
            seq_q   <= seq_d;
            e_q     <= e_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = 4'hF;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_o_q;
    assign o_busy    = busy_q;
    assign o_valid   = valid_q;
    assign o_seq     = seq_q;
    assign o_e       = e_q;
`ifdef WB_SEARCH_TIMEOUT_EN
    assign o_timeout = tmo_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_search_master.sv
// Directed bench for wb_search_master with a small register-file responder that
// supports a clean registered ack and an echoing registered ack.
module tb_wb_search_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;
    logic        i_start = 1'b0, i_ready = 1'b0;
    logic        o_busy, o_valid, o_timeout;
    logic [71:0] o_seq;
    logic [15:0] o_e;

    int n_tests = 0;
    int n_fail  = 0;

    wb_search_master #(
        .BASE_ADR(32'h3000_0000), .E_WIDTH(16), .POLL_GAP(4), .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .i_start(i_start), .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready),
        .o_seq(o_seq), .o_e(o_e), .o_timeout(o_timeout)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Responder state and transaction bookkeeping.
    int          ack_mode = 0;
    int          done_at = 3;
    int          poll_base = 0;
    logic [31:0] e_val = 32'h5A5A_1234;
    logic [31:0] s0_val = 32'hDEAD_BEEF, s1_val = 32'h0123_4567, s2_val = 32'hFFFF_FFAB;
    logic        ack_r = 1'b0;
    logic        stale_ack = 1'b0;
    int          txn_cnt = 0, wr_cnt = 0, wr_bad = 0, poll_cnt = 0, rd_cnt = 0, prot_err = 0;
    logic [63:0] wr_hist = 64'h0;
    logic        prev_take = 1'b0, prev_stb = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_adr = 32'h0;
    logic        take, status_done;

    assign wbm_ack_i   = ack_r | stale_ack;
    assign take        = wbm_cyc_o & wbm_stb_o & wbm_ack_i;
    assign status_done = (done_at != 0) && ((poll_cnt - poll_base + 1) >= done_at);

    always_comb begin
        wbm_dat_i = 32'hBAD0_BAD0;
        case (wbm_adr_o)
            32'h3000_0000: wbm_dat_i = {31'h0, status_done};
            32'h3000_0008: wbm_dat_i = e_val;
            32'h3000_0010: wbm_dat_i = s0_val;
            32'h3000_0014: wbm_dat_i = s1_val;
            32'h3000_0018: wbm_dat_i = s2_val;
            default: ;
        endcase
    end

    always @(posedge wb_clk_i) begin
        if (ack_mode == 0) ack_r <= wbm_cyc_o & wbm_stb_o & ~ack_r;
        else               ack_r <= wbm_cyc_o & wbm_stb_o;
        if (take) begin
            txn_cnt <= txn_cnt + 1;
            if (wbm_we_o) begin
                wr_cnt  <= wr_cnt + 1;
                wr_hist <= {wr_hist[31:0], wbm_dat_o};
                if (wbm_adr_o != 32'h3000_0004) wr_bad <= wr_bad + 1;
            end else if (wbm_adr_o == 32'h3000_0000) begin
                poll_cnt <= poll_cnt + 1;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
        // No back-to-back transactions, and no change while a request is pending.
        if (wb_rst_ni && ((prev_take && wbm_stb_o) ||
            (prev_stb && !prev_take && wbm_stb_o && (wbm_adr_o != prev_adr || wbm_we_o != prev_we))))
            prot_err <= prot_err + 1;
        prev_take <= take;
        prev_stb  <= wbm_stb_o;
        prev_adr  <= wbm_adr_o;
        prev_we   <= wbm_we_o;
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge wb_clk_i) i_start = 1'b1;
        @(negedge wb_clk_i) i_start = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge wb_clk_i);
            if (o_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic accept();
        @(negedge wb_clk_i) i_ready = 1'b1;
        @(negedge wb_clk_i) i_ready = 1'b0;
    endtask

    initial begin : main
        logic        ok, stable;
        int          t0, w0, p0, r0, pulses, first_pulse;
        logic [71:0] seq_snap;
        logic [15:0] e_snap;

        // Reset state, then a stale ack right after release.
        repeat (3) @(negedge wb_clk_i);
        check("rst_cyc", {71'h0, wbm_cyc_o}, 72'h0);
        check("rst_stb", {71'h0, wbm_stb_o}, 72'h0);
        check("rst_we", {71'h0, wbm_we_o}, 72'h0);
        check("rst_adr", {40'h0, wbm_adr_o}, 72'h0);
        check("rst_flags", {69'h0, o_valid, o_busy, o_timeout}, 72'h0);
        check("rst_seq", o_seq, 72'h0);
        check("rst_e", {56'h0, o_e}, 72'h0);
        wb_rst_ni = 1'b1;
        stale_ack = 1'b1;
        @(negedge wb_clk_i) stale_ack = 1'b0;
        @(negedge wb_clk_i);
        check("stale_ack_busy", {71'h0, o_busy}, 72'h0);
        check("stale_ack_txn", 72'(txn_cnt), 72'h0);

        // Nominal search: done on the 3rd poll, clean registered ack.
        ack_mode = 0; done_at = 3; poll_base = poll_cnt;
        t0 = txn_cnt; w0 = wr_cnt; p0 = poll_cnt; r0 = rd_cnt;
        pulse_start();
        check("busy_after_start", {71'h0, o_busy}, 72'h1);
        wait_valid(500, ok);
        check("run1_valid", {71'h0, ok}, 72'h1);
        check("run1_e", {56'h0, o_e}, 72'h1234);
        check("run1_seq", o_seq, 72'hAB_0123_4567_DEAD_BEEF);
        check("run1_writes", 72'(wr_cnt - w0), 72'd2);
        check("run1_wr_data", {8'h0, wr_hist}, {8'h0, 32'h1, 32'h0});
        check("run1_wr_adr", 72'(wr_bad), 72'd0);
        check("run1_polls", 72'(poll_cnt - p0), 72'd3);
        check("run1_reads", 72'(rd_cnt - r0), 72'd4);

        // Hold-off: consumer stalls 10 cycles while i_start pulses arrive.
        seq_snap = o_seq; e_snap = o_e; stable = 1'b1; t0 = txn_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            i_start = (i == 2 || i == 5);
            if (!o_valid || o_seq !== seq_snap || o_e !== e_snap) stable = 1'b0;
        end
        i_start = 1'b0;
        check("stall_stable", {71'h0, stable}, 72'h1);
        check("stall_no_txn", 72'(txn_cnt - t0), 72'd0);
        accept();
        check("accept_valid", {71'h0, o_valid}, 72'h0);
        check("accept_busy", {71'h0, o_busy}, 72'h0);
        check("accept_hold_seq", o_seq, 72'hAB_0123_4567_DEAD_BEEF);

        // Echoing registered ack: extra ack high during the idle cycle.
        ack_mode = 1; done_at = 1; poll_base = poll_cnt;
        e_val = 32'hFFFF_8001; s0_val = 32'h1111_1111; s1_val = 32'h2222_2222; s2_val = 32'h0000_00CD;
        t0 = txn_cnt; w0 = wr_cnt; p0 = poll_cnt; r0 = rd_cnt;
        pulse_start();
        wait_valid(500, ok);
        check("echo_valid", {71'h0, ok}, 72'h1);
        check("echo_e", {56'h0, o_e}, 72'h8001);
        check("echo_seq", o_seq, 72'hCD_2222_2222_1111_1111);
        check("echo_txn", 72'(txn_cnt - t0), 72'd7);
        check("echo_writes", 72'(wr_cnt - w0), 72'd2);
        check("echo_polls", 72'(poll_cnt - p0), 72'd1);
        accept();
        check("protocol", 72'(prot_err), 72'd0);

        // Reset while RD_S1 is on the bus.
        ack_mode = 0; done_at = 2; poll_base = poll_cnt;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge wb_clk_i);
            if (wbm_stb_o && wbm_adr_o == 32'h3000_0014) begin ok = 1'b1; break; end
        end
        check("reach_rd_s1", {71'h0, ok}, 72'h1);
        wb_rst_ni = 1'b0;
        #1;
        check("midrst_cyc_stb", {70'h0, wbm_cyc_o, wbm_stb_o}, 72'h0);
        check("midrst_busy_valid", {70'h0, o_busy, o_valid}, 72'h0);
        check("midrst_seq", o_seq, 72'h0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        done_at = 1; poll_base = poll_cnt;
        pulse_start();
        wait_valid(500, ok);
        check("post_rst_valid", {71'h0, ok}, 72'h1);
        check("post_rst_seq", o_seq, 72'hCD_2222_2222_1111_1111);
        accept();

        // Done never reported.
        done_at = 0; poll_base = poll_cnt; p0 = poll_cnt;
        pulses = 0; first_pulse = -1;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            @(negedge wb_clk_i);
            if (o_timeout) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
        end
`ifdef WB_SEARCH_TIMEOUT_EN
        check("tmo_pulses", 72'(pulses), 72'd1);
        check("tmo_in_time", {71'h0, (first_pulse >= 0 && first_pulse <= 130)}, 72'h1);
        check("tmo_idle", {70'h0, o_busy, o_valid}, 72'h0);
`else
        check("no_tmo_pulses", 72'(pulses), 72'd0);
        check("no_tmo_busy", {71'h0, o_busy}, 72'h1);
        check("no_tmo_polling", {71'h0, (poll_cnt - p0) > 10}, 72'h1);
        wb_rst_ni = 1'b0;
        @(negedge wb_clk_i) wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        check("no_tmo_rst_idle", {71'h0, o_busy}, 72'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
